// File: rtl/ddr_wr_dp_pkg.sv
// rtl/ddr_wr_dp_pkg.sv - shared types, PHY word layout and parameter checks for ddr_wr_dp
package ddr_wr_dp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_PRE  = 3'd2,
      ST_DATA = 3'd3,
      ST_POST = 3'd4
   } state_e;

   localparam int TX_W       = 36;
   localparam int DAT_HI_MSB = 35;
   localparam int DAT_HI_LSB = 20;
   localparam int DAT_LO_MSB = 19;
   localparam int DAT_LO_LSB = 4;
   localparam int SEL_MSB    = 3;
   localparam int SEL_LSB    = 0;

   function automatic bit bl_legal(int bl);
      return (bl == 4) || (bl == 8);
   endfunction

   // First beat goes in the upper half, matching the PHY's tx_dat_i ordering.
   function automatic logic [TX_W-1:0] pack_tx(logic [31:0] dat, logic [3:0] sel);
      logic [TX_W-1:0] w;
      w                         = '0;
      w[DAT_HI_MSB:DAT_HI_LSB]  = dat[31:16];
      w[DAT_LO_MSB:DAT_LO_LSB]  = dat[15:0];
      w[SEL_MSB:SEL_LSB]        = sel;
      return w;
   endfunction

endpackage

// File: rtl/ddr_wr_dp_if.sv
// rtl/ddr_wr_dp_if.sv - command, Tx FIFO and PHY-side signals of the write datapath
interface ddr_wr_dp_if;
   import ddr_wr_dp_pkg::*;

   logic            wr_cmd_i;
   logic [31:0]     fifo_dat_i;
   logic [3:0]      fifo_sel_i;
   logic            fifo_empty_i;
   logic            err_clr_i;
   logic            fifo_rd_o;
   logic [TX_W-1:0] tx_dat_o;
   logic            dq_en_o;
   logic            dqm_en_o;
   logic            busy_o;
   logic            wr_ack_o;
   logic            underrun_o;
   logic            cmd_err_o;

   modport slave (
      input  wr_cmd_i, fifo_dat_i, fifo_sel_i, fifo_empty_i, err_clr_i,
      output fifo_rd_o, tx_dat_o, dq_en_o, dqm_en_o, busy_o, wr_ack_o,
             underrun_o, cmd_err_o
   );

   modport master (
      output wr_cmd_i, fifo_dat_i, fifo_sel_i, fifo_empty_i, err_clr_i,
      input  fifo_rd_o, tx_dat_o, dq_en_o, dqm_en_o, busy_o, wr_ack_o,
             underrun_o, cmd_err_o
   );

endinterface

// File: rtl/ddr_wr_dp.sv
// rtl/ddr_wr_dp.sv - DDR write sequencer: WL wait, DQS preamble, BL/2 data words, postamble
module ddr_wr_dp
   import ddr_wr_dp_pkg::*;
#(
   parameter int BL = 4,
   parameter int WL = 2
) (
   input logic         clk_0,
   input logic         rst_n,
   ddr_wr_dp_if.slave  bus
);

   // An illegal BL falls back to the BL=4 word count.
   localparam logic [1:0] BEAT_LAST = bl_legal(BL) ? 2'(BL/2 - 1) : 2'd1;
   localparam logic [3:0] WAIT_INIT = 4'(WL - 2);
   localparam bit         WL_SHORT  = (WL <= 2);

   state_e          state_q, state_d;
   logic [3:0]      wait_q, wait_d;
   logic [1:0]      beat_q, beat_d;
   logic            pend_q, pend_d;
   logic [TX_W-1:0] tx_dat_q, tx_dat_d;
   logic            dq_en_q, dq_en_d;
   logic            dqm_en_q, dqm_en_d;
   logic            busy_q, busy_d;
   logic            wr_ack_q, wr_ack_d;
   logic            underrun_q, underrun_d;
   logic            cmd_err_q, cmd_err_d;
   logic            fifo_rd;
   logic            launch;

   always_ff @(posedge clk_0 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wait_q     <= '0;
         beat_q     <= '0;
         pend_q     <= 1'b0;
         tx_dat_q   <= '0;
         dq_en_q    <= 1'b0;
         dqm_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         wr_ack_q   <= 1'b0;
         underrun_q <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         beat_q     <= beat_d;
         pend_q     <= pend_d;
         tx_dat_q   <= tx_dat_d;
         dq_en_q    <= dq_en_d;
         dqm_en_q   <= dqm_en_d;
         busy_q     <= busy_d;
         wr_ack_q   <= wr_ack_d;
         underrun_q <= underrun_d;
         cmd_err_q  <= cmd_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      beat_d     = beat_q;
      pend_d     = pend_q;
      tx_dat_d   = '0;
      dq_en_d    = 1'b0;
      dqm_en_d   = 1'b0;
      wr_ack_d   = 1'b0;
      fifo_rd    = 1'b0;
      launch     = 1'b0;
      underrun_d = underrun_q & ~bus.err_clr_i;
      cmd_err_d  = cmd_err_q & ~bus.err_clr_i;

      // POST handles its own command arrival since the slot frees there.
      if (bus.wr_cmd_i && (state_q != ST_IDLE) && (state_q != ST_POST)) begin
         if (pend_q) begin
            cmd_err_d = 1'b1;
         end else begin
            pend_d = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.wr_cmd_i) begin
               launch = 1'b1;
            end
         end
         ST_WAIT: begin
            wait_d = wait_q - 4'd1;
            if (wait_q <= 4'd1) begin
               state_d = ST_PRE;
            end
         end
         ST_PRE: begin
            dq_en_d  = 1'b1;
            dqm_en_d = 1'b1;
            beat_d   = BEAT_LAST;
            state_d  = ST_DATA;
         end
         ST_DATA: begin
            dq_en_d = 1'b1;
            if (!bus.fifo_empty_i) begin
               fifo_rd  = 1'b1;
               tx_dat_d = pack_tx(bus.fifo_dat_i, bus.fifo_sel_i);
            end else begin
               tx_dat_d   = pack_tx(bus.fifo_dat_i, 4'b0000);
               underrun_d = 1'b1;
            end
            if (beat_q == 2'd0) begin
               state_d = ST_POST;
            end else begin
               beat_d = beat_q - 2'd1;
            end
         end
         ST_POST: begin
            dq_en_d  = 1'b1;
            dqm_en_d = 1'b1;
            wr_ack_d = 1'b1;
            if (pend_q) begin
               pend_d = 1'b0;
               launch = 1'b1;
               if (bus.wr_cmd_i) begin
                  cmd_err_d = 1'b1;
               end
            end else if (bus.wr_cmd_i) begin
               launch = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (launch) begin
         wait_d  = WAIT_INIT;
         state_d = WL_SHORT ? ST_PRE : ST_WAIT;
      end

      busy_d = (state_d != ST_IDLE) || pend_d;
   end

   assign bus.fifo_rd_o  = fifo_rd;
   assign bus.tx_dat_o   = tx_dat_q;
   assign bus.dq_en_o    = dq_en_q;
   assign bus.dqm_en_o   = dqm_en_q;
   assign bus.busy_o     = busy_q;
   assign bus.wr_ack_o   = wr_ack_q;
   assign bus.underrun_o = underrun_q;
   assign bus.cmd_err_o  = cmd_err_q;

endmodule

// File: tb/tb_ddr_wr_dp.sv
// tb/tb_ddr_wr_dp.sv - self-checking bench for ddr_wr_dp (BL=4/WL=2 and BL=8/WL=5 instances)
module tb_ddr_wr_dp;

   localparam logic [31:0] IDLE_PAT = 32'hFFFF_0000;

   typedef struct {
      bit wr_cmd;
      bit err_clr;
      bit dq;
      bit dqm;
      bit ack;
      bit busy;
      bit cmd_err;
   } vec_t;

   logic clk_0;
   logic rst_n;
   int   total;
   int   bad;

   logic [35:0] fa[$];
   logic [35:0] ea[$];
   logic [35:0] fb[$];
   logic [35:0] eb[$];
   int          pops_a;
   int          pops_b;
   bit          rd_a;
   bit          rd_b;
   vec_t        vt[24];

   ddr_wr_dp_if ifa();
   ddr_wr_dp_if ifb();

   ddr_wr_dp #(.BL(4), .WL(2)) u_a (.clk_0(clk_0), .rst_n(rst_n), .bus(ifa.slave));
   ddr_wr_dp #(.BL(8), .WL(5)) u_b (.clk_0(clk_0), .rst_n(rst_n), .bus(ifb.slave));

   always #5 clk_0 = ~clk_0;

   task automatic check(input string nm, input logic [35:0] got, input logic [35:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   task automatic drive_fifos();
      ifa.fifo_empty_i = (fa.size() == 0);
      ifa.fifo_dat_i   = (fa.size() == 0) ? IDLE_PAT : fa[0][35:4];
      ifa.fifo_sel_i   = (fa.size() == 0) ? 4'h0 : fa[0][3:0];
      ifb.fifo_empty_i = (fb.size() == 0);
      ifb.fifo_dat_i   = (fb.size() == 0) ? IDLE_PAT : fb[0][35:4];
      ifb.fifo_sel_i   = (fb.size() == 0) ? 4'h0 : fb[0][3:0];
   endtask

   task automatic load_a(input logic [31:0] d, input logic [3:0] s);
      fa.push_back({d, s});
      ea.push_back({d, s});
      drive_fifos();
   endtask

   task automatic load_b(input logic [31:0] d, input logic [3:0] s);
      fb.push_back({d, s});
      eb.push_back({d, s});
      drive_fifos();
   endtask

   // One clock: sample pops mid-cycle, pop the FIFO model after the edge, score beats.
   task automatic tick();
      logic [35:0] e;
      @(negedge clk_0);
      rd_a = ifa.fifo_rd_o;
      rd_b = ifb.fifo_rd_o;
      if (rd_a) pops_a++;
      if (rd_b) pops_b++;
      @(posedge clk_0);
      #1;
      if (rd_a && fa.size() > 0) void'(fa.pop_front());
      if (rd_b && fb.size() > 0) void'(fb.pop_front());
      drive_fifos();
      if (ifa.dq_en_o && !ifa.dqm_en_o) begin
         if (ea.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_beat_a: got unexpected beat %h want none", ifa.tx_dat_o);
         end else begin
            e = ea.pop_front();
            check("tx_beat_a", ifa.tx_dat_o, e);
         end
      end else begin
         check("tx_idle_a", ifa.tx_dat_o, 36'h0);
      end
      if (ifb.dq_en_o && !ifb.dqm_en_o) begin
         if (eb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_beat_b: got unexpected beat %h want none", ifb.tx_dat_o);
         end else begin
            e = eb.pop_front();
            check("tx_beat_b", ifb.tx_dat_o, e);
         end
      end else begin
         check("tx_idle_b", ifb.tx_dat_o, 36'h0);
      end
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         ifa.wr_cmd_i  = vt[i].wr_cmd;
         ifa.err_clr_i = vt[i].err_clr;
         tick();
         ifa.wr_cmd_i  = 1'b0;
         ifa.err_clr_i = 1'b0;
         check($sformatf("r%0d_dq_en", i), ifa.dq_en_o, vt[i].dq);
         check($sformatf("r%0d_dqm_en", i), ifa.dqm_en_o, vt[i].dqm);
         check($sformatf("r%0d_wr_ack", i), ifa.wr_ack_o, vt[i].ack);
         check($sformatf("r%0d_busy", i), ifa.busy_o, vt[i].busy);
         check($sformatf("r%0d_cmd_err", i), ifa.cmd_err_o, vt[i].cmd_err);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_a"}, ifa.tx_dat_o, 36'h0);
      check({tag, "_dq_a"}, ifa.dq_en_o, 1'b0);
      check({tag, "_dqm_a"}, ifa.dqm_en_o, 1'b0);
      check({tag, "_busy_a"}, ifa.busy_o, 1'b0);
      check({tag, "_ack_a"}, ifa.wr_ack_o, 1'b0);
      check({tag, "_rd_a"}, ifa.fifo_rd_o, 1'b0);
      check({tag, "_under_a"}, ifa.underrun_o, 1'b0);
      check({tag, "_cerr_a"}, ifa.cmd_err_o, 1'b0);
      check({tag, "_dq_b"}, ifb.dq_en_o, 1'b0);
      check({tag, "_busy_b"}, ifb.busy_o, 1'b0);
      check({tag, "_under_b"}, ifb.underrun_o, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int p0;
      total = 0;
      bad   = 0;
      pops_a = 0;
      pops_b = 0;
      clk_0 = 1'b0;
      rst_n = 1'b0;
      ifa.wr_cmd_i = 1'b0; ifa.err_clr_i = 1'b0;
      ifb.wr_cmd_i = 1'b0; ifb.err_clr_i = 1'b0;
      drive_fifos();

      // BL=4 single burst (rows 0..5), then back-to-back/pending/drop (rows 6..23)
      vt[0]  = '{1,0, 0,0,0,1,0};
      vt[1]  = '{0,0, 1,1,0,1,0};
      vt[2]  = '{0,0, 1,0,0,1,0};
      vt[3]  = '{0,0, 1,0,0,1,0};
      vt[4]  = '{0,0, 1,1,1,0,0};
      vt[5]  = '{0,0, 0,0,0,0,0};
      vt[6]  = '{1,0, 0,0,0,1,0};
      vt[7]  = '{0,0, 1,1,0,1,0};
      vt[8]  = '{1,0, 1,0,0,1,0};
      vt[9]  = '{0,0, 1,0,0,1,0};
      vt[10] = '{0,0, 1,1,1,1,0};
      vt[11] = '{0,0, 1,1,0,1,0};
      vt[12] = '{0,0, 1,0,0,1,0};
      vt[13] = '{0,0, 1,0,0,1,0};
      vt[14] = '{1,0, 1,1,1,1,0};
      vt[15] = '{0,0, 1,1,0,1,0};
      vt[16] = '{1,0, 1,0,0,1,0};
      vt[17] = '{1,0, 1,0,0,1,1};
      vt[18] = '{0,0, 1,1,1,1,1};
      vt[19] = '{0,0, 1,1,0,1,1};
      vt[20] = '{0,0, 1,0,0,1,1};
      vt[21] = '{0,0, 1,0,0,1,1};
      vt[22] = '{0,0, 1,1,1,0,1};
      vt[23] = '{0,1, 0,0,0,0,0};

      tick();
      tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();
      tick();

      load_a(32'hA5A5_1234, 4'hF);
      load_a(32'hDEAD_BEEF, 4'h3);
      tick();
      p0 = pops_a;
      run_rows(0, 5);
      check("t1_pops", 36'(pops_a - p0), 36'd2);
      check("t1_sb_left", 36'(ea.size()), 36'd0);

      for (int i = 0; i < 8; i++) load_a(32'h1000_0000 + 32'(i * 32'h0101_0101), 4'(i + 1));
      tick();
      p0 = pops_a;
      run_rows(6, 23);
      check("b2b_pops", 36'(pops_a - p0), 36'd8);
      check("b2b_sb_left", 36'(ea.size()), 36'd0);

      // Underrun raised while err_clr is held: set must win, then clear once data ends.
      ea.push_back({IDLE_PAT, 4'h0});
      ea.push_back({IDLE_PAT, 4'h0});
      p0 = pops_a;
      ifa.err_clr_i = 1'b1;
      ifa.wr_cmd_i  = 1'b1;
      tick();
      ifa.wr_cmd_i  = 1'b0;
      tick();
      tick();
      tick();
      check("setwin_under", ifa.underrun_o, 1'b1);
      tick();
      check("setwin_clr", ifa.underrun_o, 1'b0);
      ifa.err_clr_i = 1'b0;
      check("setwin_pops", 36'(pops_a - p0), 36'd0);
      tick();
      tick();

      // BL=8, WL=5 with only two of four words available
      load_b(32'h0BAD_CAFE, 4'h5);
      load_b(32'h7777_8888, 4'hA);
      tick();
      tick();
      p0 = pops_b;
      eb.push_back({IDLE_PAT, 4'h0});
      eb.push_back({IDLE_PAT, 4'h0});
      ifb.wr_cmd_i = 1'b1;
      tick();
      ifb.wr_cmd_i = 1'b0;
      check("b_busy", ifb.busy_o, 1'b1);
      tick(); tick(); tick();
      check("b_pre_dq_n3", ifb.dq_en_o, 1'b0);
      tick();
      check("b_pre_dq", ifb.dq_en_o, 1'b1);
      check("b_pre_dqm", ifb.dqm_en_o, 1'b1);
      tick(); tick();
      check("b_under_early", ifb.underrun_o, 1'b0);
      tick();
      check("b_under_set", ifb.underrun_o, 1'b1);
      tick();
      tick();
      check("b_post_ack", ifb.wr_ack_o, 1'b1);
      check("b_post_dqm", ifb.dqm_en_o, 1'b1);
      check("b_post_dq", ifb.dq_en_o, 1'b1);
      tick();
      check("b_after_dq", ifb.dq_en_o, 1'b0);
      check("b_under_sticky", ifb.underrun_o, 1'b1);
      check("b_pops", 36'(pops_b - p0), 36'd2);
      check("b_sb_left", 36'(eb.size()), 36'd0);
      ifb.err_clr_i = 1'b1;
      tick();
      ifb.err_clr_i = 1'b0;
      check("b_under_clr", ifb.underrun_o, 1'b0);

      // Async reset during the first data beat
      load_a(32'h1111_2222, 4'hC);
      load_a(32'h3333_4444, 4'h6);
      tick();
      ifa.wr_cmd_i = 1'b1;
      tick();
      ifa.wr_cmd_i = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      tick();
      rst_n = 1'b1;
      ea.delete();
      fa.delete();
      fa.push_back({32'h5555_6666, 4'hF});
      drive_fifos();

      // Idle with a non-empty FIFO: nothing may move
      p0 = pops_a;
      for (int i = 0; i < 100; i++) begin
         tick();
         check("idle_quiet", {ifa.fifo_rd_o, ifa.dq_en_o, ifa.busy_o, ifa.tx_dat_o != 36'h0}, 36'h0);
      end
      check("idle_pops", 36'(pops_a - p0), 36'd0);
      fa.delete();
      drive_fifos();
      tick();

      check("end_sb_a", 36'(ea.size()), 36'd0);
      check("end_sb_b", 36'(eb.size()), 36'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
